// File: rtl/kmeans_pkg.sv
// Shared constants, vector types and scheduler state for the k_means sequencing logic.
package kmeans_pkg;

  localparam int unsigned NUM_CENTROIDS = 7;
  localparam int unsigned X_W           = 9;
  localparam int unsigned Y_W           = 8;

  typedef logic [NUM_CENTROIDS-1:0][X_W-1:0] cent_x_t;
  typedef logic [NUM_CENTROIDS-1:0][Y_W-1:0] cent_y_t;

  // Default spread: x_i = 40*(i+1), all y on row 90 (lane 0 is the rightmost entry).
  localparam cent_x_t DEFAULT_SEED_X = {9'd280, 9'd240, 9'd200, 9'd160, 9'd120, 9'd80, 9'd40};
  localparam cent_y_t DEFAULT_SEED_Y = {7{8'd90}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STORE = 2'd1,
    ST_SOLVE = 2'd2
  } sched_state_e;

endpackage

// File: rtl/kmeans_frame_scheduler_seed_select.sv
// Seed selection for k_means: tracks whether a usable previous result exists and
// holds the seed/count register stable between arms.
module kmeans_seed_select
  import kmeans_pkg::*;
(
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         arm_in,
  input  logic [2:0]   num_balls_in,
  input  logic         publish_in,
  input  logic         abort_in,
  input  cent_x_t      last_x_in,
  input  cent_y_t      last_y_in,
  output logic [2:0]   num_balls_out,
  output cent_x_t      seed_x_out,
  output cent_y_t      seed_y_out
);

  logic       have_result;
  logic [2:0] last_count;

  // Load seeds only on arm (hold otherwise); record result ownership on publish/abort.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      have_result   <= 1'b0;
      last_count    <= '0;
      num_balls_out <= 3'd1;
      seed_x_out    <= DEFAULT_SEED_X;
      seed_y_out    <= DEFAULT_SEED_Y;
    end else begin
      if (arm_in) begin
        num_balls_out <= num_balls_in;
        if (have_result && (num_balls_in == last_count)) begin
          seed_x_out <= last_x_in;
          seed_y_out <= last_y_in;
        end else begin
          seed_x_out <= DEFAULT_SEED_X;
          seed_y_out <= DEFAULT_SEED_Y;
        end
      end
      if (publish_in) begin
        have_result <= 1'b1;
        last_count  <= num_balls_out;
      end else if (abort_in) begin
        have_result <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/kmeans_frame_scheduler.sv
// Per-frame sequencer for the k_means solver: arm/seed, STORE for one frame,
// SOLVE under a watchdog, then publish centroids with a one-cycle strobe.
module kmeans_frame_scheduler
  import kmeans_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter int unsigned DROP_W         = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              frame_start_in,
  input  logic [2:0]        num_balls_in,
  input  logic              km_valid_in,
  input  cent_x_t           km_centroids_x_in,
  input  cent_y_t           km_centroids_y_in,
  output logic              km_rst_out,
  output logic              km_new_frame_out,
  output logic [2:0]        km_num_balls_out,
  output cent_x_t           km_seed_x_out,
  output cent_y_t           km_seed_y_out,
  output cent_x_t           centroids_x_out,
  output cent_y_t           centroids_y_out,
  output logic              result_valid_out,
  output logic              busy_out,
  output logic              timeout_out,
  output logic [DROP_W-1:0] dropped_frames_out
);

  localparam int unsigned       WD_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]   WD_MAX = WD_W'(TIMEOUT_CYCLES);

  sched_state_e    state;
  logic [WD_W-1:0] wd_count;
  logic            arm;
  logic            publish;
  logic            abort;

  // Event decode shared by the FSM and the seed register.
  always_comb begin
    arm     = (state == ST_IDLE) && frame_start_in && (num_balls_in != 3'd0);
    publish = (state == ST_SOLVE) && km_valid_in;
    abort   = (state == ST_SOLVE) && !km_valid_in && (wd_count == WD_MAX);
  end

  kmeans_seed_select u_seed_select (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .arm_in        (arm),
    .num_balls_in  (num_balls_in),
    .publish_in    (publish),
    .abort_in      (abort),
    .last_x_in     (centroids_x_out),
    .last_y_in     (centroids_y_out),
    .num_balls_out (km_num_balls_out),
    .seed_x_out    (km_seed_x_out),
    .seed_y_out    (km_seed_y_out)
  );

  // FSM, watchdog, result register, drop counter and output strobes.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state              <= ST_IDLE;
      wd_count           <= '0;
      km_rst_out         <= 1'b1;
      km_new_frame_out   <= 1'b0;
      result_valid_out   <= 1'b0;
      timeout_out        <= 1'b0;
      busy_out           <= 1'b0;
      centroids_x_out    <= '0;
      centroids_y_out    <= '0;
      dropped_frames_out <= '0;
    end else begin
      km_rst_out       <= 1'b0;
      km_new_frame_out <= 1'b0;
      result_valid_out <= 1'b0;
      timeout_out      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arm) begin
            km_rst_out <= 1'b1;
            busy_out   <= 1'b1;
            state      <= ST_STORE;
          end
        end
        ST_STORE: begin
          if (frame_start_in) begin
            km_new_frame_out <= 1'b1;
            wd_count         <= '0;
            state            <= ST_SOLVE;
          end
        end
        ST_SOLVE: begin
          if (frame_start_in && (dropped_frames_out != '1)) begin
            dropped_frames_out <= dropped_frames_out + DROP_W'(1);
          end
          // Valid takes priority over a watchdog expiry in the same cycle.
          if (publish) begin
            centroids_x_out  <= km_centroids_x_in;
            centroids_y_out  <= km_centroids_y_in;
            result_valid_out <= 1'b1;
            busy_out         <= 1'b0;
            state            <= ST_IDLE;
          end else if (abort) begin
            timeout_out <= 1'b1;
            km_rst_out  <= 1'b1;
            busy_out    <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            wd_count <= wd_count + WD_W'(1);
          end
        end
        default: begin
          busy_out <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kmeans_frame_scheduler.sv
// Randomized + directed bench for kmeans_frame_scheduler against a behavioural model.
module tb_kmeans_frame_scheduler;
  import kmeans_pkg::*;

  localparam int TIMEOUT = 1000;
  localparam int DROPW   = 8;
  localparam int DROPMAX = 255;

  logic             clk_in = 1'b0;
  logic             rst_in, frame_start_in, km_valid_in;
  logic [2:0]       num_balls_in;
  cent_x_t          kx;
  cent_y_t          ky;
  logic             km_rst_out, km_new_frame_out, result_valid_out, busy_out, timeout_out;
  logic [2:0]       km_num_balls_out;
  cent_x_t          km_seed_x_out, centroids_x_out;
  cent_y_t          km_seed_y_out, centroids_y_out;
  logic [DROPW-1:0] dropped_frames_out;

  kmeans_frame_scheduler #(.TIMEOUT_CYCLES(TIMEOUT), .DROP_W(DROPW)) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .frame_start_in     (frame_start_in),
    .num_balls_in       (num_balls_in),
    .km_valid_in        (km_valid_in),
    .km_centroids_x_in  (kx),
    .km_centroids_y_in  (ky),
    .km_rst_out         (km_rst_out),
    .km_new_frame_out   (km_new_frame_out),
    .km_num_balls_out   (km_num_balls_out),
    .km_seed_x_out      (km_seed_x_out),
    .km_seed_y_out      (km_seed_y_out),
    .centroids_x_out    (centroids_x_out),
    .centroids_y_out    (centroids_y_out),
    .result_valid_out   (result_valid_out),
    .busy_out           (busy_out),
    .timeout_out        (timeout_out),
    .dropped_frames_out (dropped_frames_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  typedef enum {M_IDLE, M_CAPTURE, M_SOLVING} mphase_t;
  mphase_t m_phase;
  int  cyc = 0;
  int  solve_start;
  int  drops;
  bit  have;
  int  last_nb, e_nb;
  int  e_sx[7], e_sy[7], e_cx[7], e_cy[7];
  bit  e_kmrst, e_nf, e_rv, e_to, e_busy;

  function automatic logic [63:0] pack_lanes(input int a[7], input int w);
    logic [63:0] r = '0;
    for (int i = 0; i < 7; i++) r = r | (64'(a[i]) << (w * i));
    return r;
  endfunction

  task automatic default_seeds();
    for (int i = 0; i < 7; i++) begin
      e_sx[i] = 40 * (i + 1);
      e_sy[i] = 90;
    end
  endtask

  task automatic model_step();
    if (rst_in) begin
      m_phase = M_IDLE;
      e_kmrst = 1; e_nf = 0; e_rv = 0; e_to = 0; e_busy = 0;
      have = 0; e_nb = 1; drops = 0;
      default_seeds();
      for (int i = 0; i < 7; i++) begin e_cx[i] = 0; e_cy[i] = 0; end
      return;
    end
    e_kmrst = 0; e_nf = 0; e_rv = 0; e_to = 0;
    case (m_phase)
      M_IDLE: if (frame_start_in && num_balls_in != 0) begin
        e_nb = int'(num_balls_in);
        if (have && e_nb == last_nb) begin
          e_sx = e_cx; e_sy = e_cy;
        end else begin
          default_seeds();
        end
        e_kmrst = 1; e_busy = 1; m_phase = M_CAPTURE;
      end
      M_CAPTURE: if (frame_start_in) begin
        e_nf = 1; solve_start = cyc + 1; m_phase = M_SOLVING;
      end
      M_SOLVING: begin
        if (frame_start_in) drops++;
        if (km_valid_in) begin
          for (int i = 0; i < 7; i++) begin e_cx[i] = int'(kx[i]); e_cy[i] = int'(ky[i]); end
          have = 1; last_nb = e_nb; e_rv = 1; e_busy = 0; m_phase = M_IDLE;
        end else if (cyc - solve_start == TIMEOUT) begin
          e_to = 1; e_kmrst = 1; have = 0; e_busy = 0; m_phase = M_IDLE;
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check_val("km_rst", km_rst_out, e_kmrst);
    check_val("new_frame", km_new_frame_out, e_nf);
    check_val("result_valid", result_valid_out, e_rv);
    check_val("timeout", timeout_out, e_to);
    check_val("busy", busy_out, e_busy);
    check_val("num_balls", km_num_balls_out, e_nb);
    check_val("seed_x", km_seed_x_out, pack_lanes(e_sx, 9));
    check_val("seed_y", km_seed_y_out, pack_lanes(e_sy, 8));
    check_val("cent_x", centroids_x_out, pack_lanes(e_cx, 9));
    check_val("cent_y", centroids_y_out, pack_lanes(e_cy, 8));
    check_val("dropped", dropped_frames_out, (drops > DROPMAX) ? DROPMAX : drops);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_in);
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic idle(input int n);
    frame_start_in = 0; km_valid_in = 0;
    repeat (n) tick();
  endtask

  task automatic pulse_fs();
    frame_start_in = 1; tick(); frame_start_in = 0;
  endtask

  task automatic rand_k();
    for (int i = 0; i < 7; i++) begin
      kx[i] = 9'($urandom);
      ky[i] = 8'($urandom);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout bench did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    logic [8:0] r2_x0;
    rst_in = 1; frame_start_in = 0; km_valid_in = 0; num_balls_in = 3'd3;
    rand_k();
    tick(); tick();
    check_val("rst_kmrst", km_rst_out, 1);
    check_val("rst_nb", km_num_balls_out, 1);
    check_val("rst_seed_x6", km_seed_x_out[6], 280);
    check_val("rst_seed_y0", km_seed_y_out[0], 90);
    rst_in = 0;

    // Nominal session.
    idle(7);
    pulse_fs();
    check_val("nom_arm_rst", km_rst_out, 1);
    check_val("nom_arm_busy", busy_out, 1);
    idle(1);
    check_val("nom_rst_once", km_rst_out, 0);
    idle(488);
    pulse_fs();
    check_val("nom_newframe", km_new_frame_out, 1);
    idle(1);
    check_val("nom_newframe_once", km_new_frame_out, 0);
    idle(398);
    rand_k(); kx[0] = 9'd50; kx[1] = 9'd150; kx[2] = 9'd250;
    km_valid_in = 1; tick(); km_valid_in = 0;
    check_val("nom_rv", result_valid_out, 1);
    check_val("nom_x0", centroids_x_out[0], 50);
    check_val("nom_x1", centroids_x_out[1], 150);
    check_val("nom_x2", centroids_x_out[2], 250);
    check_val("nom_busy", busy_out, 0);

    // Tracking reseed, then simultaneous valid + frame_start.
    idle(3);
    pulse_fs();
    check_val("trk_seed0", km_seed_x_out[0], 50);
    check_val("trk_seed2", km_seed_x_out[2], 250);
    idle(20); pulse_fs(); idle(50);
    rand_k(); r2_x0 = kx[0];
    km_valid_in = 1; frame_start_in = 1; tick(); km_valid_in = 0;
    check_val("sim_rv", result_valid_out, 1);
    check_val("sim_drop", dropped_frames_out, 1);
    tick(); frame_start_in = 0;
    check_val("rearm_rst", km_rst_out, 1);
    check_val("rearm_seed0", km_seed_x_out[0], r2_x0);

    // Watchdog expiry.
    idle(5); pulse_fs();
    k = 1;
    while (k <= TIMEOUT + 100) begin
      tick();
      if (timeout_out) break;
      k++;
    end
    check_val("wd_latency", k, TIMEOUT + 1);
    check_val("wd_kmrst", km_rst_out, 1);
    check_val("wd_keep_x0", centroids_x_out[0], r2_x0);
    idle(2); pulse_fs();
    check_val("wd_default_seed0", km_seed_x_out[0], 40);

    // Drop saturation.
    idle(4); pulse_fs();
    frame_start_in = 1; repeat (300) tick(); frame_start_in = 0;
    check_val("drop_sat", dropped_frames_out, 255);
    rand_k(); km_valid_in = 1; tick(); km_valid_in = 0;

    // Count change forces defaults, then mid-SOLVE reset.
    num_balls_in = 3'd4;
    idle(2); pulse_fs();
    check_val("nb4", km_num_balls_out, 4);
    check_val("nb4_seed3", km_seed_x_out[3], 160);
    check_val("nb4_y1", km_seed_y_out[1], 90);
    idle(10); pulse_fs(); idle(20);
    rst_in = 1; tick(); rst_in = 0;
    check_val("mrst_kmrst", km_rst_out, 1);
    check_val("mrst_cx", centroids_x_out, 0);
    check_val("mrst_drop", dropped_frames_out, 0);
    rand_k(); km_valid_in = 1; tick(); km_valid_in = 0;
    check_val("mrst_valid_ignored", result_valid_out, 0);

    // Disabled.
    num_balls_in = 3'd0;
    repeat (5) begin idle(7); pulse_fs(); check_val("dis_rst", km_rst_out, 0); check_val("dis_busy", busy_out, 0); end

    // Randomized traffic.
    num_balls_in = 3'd2;
    for (int n = 0; n < 20000; n++) begin
      rst_in         = ($urandom_range(0, 4999) == 0);
      frame_start_in = ($urandom_range(0, 39) == 0);
      km_valid_in    = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 99) == 0) num_balls_in = 3'($urandom_range(0, 7));
      rand_k();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/kmeans_frame_scheduler.md
# kmeans_frame_scheduler

- Per-frame controller that sequences the `k_means` centroid solver.
- Resets and seeds the solver once per capture frame, with either its own previous result (ball tracking) or the default spread.
- Times the STORE/solve phases off camera frame boundaries and runs a solve watchdog.
- Publishes solved centroids to the downstream juggling-pattern logic with a one-cycle valid strobe.
- Sits between the camera frame-sync logic and the `k_means` instance; fully owns that instance's `rst_in`, `new_frame`, `num_balls` and `centroids_*_in`.

## Interface
Parameters:
- TIMEOUT_CYCLES, 2_000_000: maximum cycles allowed in SOLVE before abort.
- DROP_W, 8: width of the saturating dropped-frame counter.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  synchronous, active-high reset.
- frame_start_in  in  1  one-cycle pulse at the start of each camera frame.
- num_balls_in  in  3  requested centroid count (1..7); 0 means disabled.
- km_valid_in  in  1  `k_means` data_valid_out.
- km_centroids_x_in  in  9×7  `k_means` centroids_x_out.
- km_centroids_y_in  in  8×7  `k_means` centroids_y_out.
- km_rst_out  out  1  drives `k_means` rst_in.
- km_new_frame_out  out  1  drives `k_means` new_frame.
- km_num_balls_out  out  3  drives `k_means` num_balls.
- km_seed_x_out  out  9×7  drives `k_means` centroids_x_in.
- km_seed_y_out  out  8×7  drives `k_means` centroids_y_in.
- centroids_x_out  out  9×7  last published x results.
- centroids_y_out  out  8×7  last published y results.
- result_valid_out  out  1  one-cycle strobe when centroids_*_out update.
- busy_out  out  1  high in STORE or SOLVE.
- timeout_out  out  1  one-cycle strobe on watchdog abort.
- dropped_frames_out  out  DROP_W  saturating count of frame_start_in pulses ignored in SOLVE.

## Operation
States are IDLE, STORE and SOLVE.

- IDLE:
  - Triggered by frame_start_in with num_balls_in≠0.
  - Latch num_balls_in into km_num_balls_out.
  - Select seeds:
    - If have_result=1 and the latched count equals the count of the last result, use the last centroids_*_out.
    - Otherwise use the package default seeds: x_i = 40·(i+1), y_i = 90.
  - Pulse km_rst_out; go to STORE.
  - frame_start_in with num_balls_in=0 leaves the block in IDLE and produces no output activity.
- STORE: `k_means` captures the mask for the whole frame. The next frame_start_in pulses km_new_frame_out, clears the watchdog and moves to SOLVE.
- SOLVE:
  - On km_valid_in, copy km_centroids_* to centroids_*_out, set have_result, pulse result_valid_out and go to IDLE.
  - The watchdog counts cycles in SOLVE. On reaching TIMEOUT_CYCLES without valid:
    - pulse timeout_out and km_rst_out;
    - clear have_result;
    - keep centroids_*_out unchanged;
    - go to IDLE.
  - frame_start_in during SOLVE increments dropped_frames_out, saturating at all-ones, and does not re-arm.
- Seeds and km_num_balls_out are held constant from the km_rst_out pulse until the block leaves SOLVE.
- Boundary cases:
  - km_valid_in and watchdog expiry in the same cycle: valid wins, no timeout.
  - km_valid_in and frame_start_in in the same cycle: result is published, the frame counts as dropped, and the block goes to IDLE. Arming waits for the following frame_start_in.
  - km_valid_in outside SOLVE is ignored.
  - A num_balls_in change takes effect only at the next arm.
- Reset (including mid-STORE or mid-SOLVE) sets, on the next cycle:
  - state IDLE, km_rst_out=1, have_result=0;
  - km_new_frame_out, result_valid_out, timeout_out and busy_out all 0;
  - km_num_balls_out=1; km_seed_*_out = default seeds;
  - centroids_*_out all 0; dropped_frames_out=0.

## Timing
- All outputs are registered.
- frame_start_in at cycle t in IDLE: km_rst_out=1 and busy_out=1 at t+1 only; seeds are valid at t+1.
- frame_start_in at cycle s in STORE: km_new_frame_out=1 at s+1 only; the state is SOLVE from s+1.
- km_valid_in at cycle v: centroids_*_out updated and result_valid_out=1 at v+1; busy_out=0 at v+1.
- Watchdog:
  - The counter equals 0 in the first SOLVE cycle and has width $clog2(TIMEOUT_CYCLES+1).
  - Abort strobes appear TIMEOUT_CYCLES+1 cycles after entering SOLVE.
- A new arm is possible at the first frame_start_in sampled in IDLE, at the earliest one cycle after leaving SOLVE.

## Structure
- Shared package `kmeans_pkg` holds:
  - NUM_CENTROIDS=7, X_W=9, Y_W=8;
  - default seed constant arrays;
  - the scheduler state enum.
- One natural sub-module, `kmeans_seed_select`, holds have_result, the last count, and the seed mux register with hold enable.
- The watchdog counter and FSM stay in the top module.

## Test plan
- Nominal session: reset, num_balls_in=3, frame_start at cycles 10 and 500, km_valid at 900 with x={50,150,250}.
  - km_rst_out high at cycle 11 only.
  - km_new_frame_out high at cycle 501 only.
  - result_valid_out high at cycle 901 with centroids_x_out={50,150,250}.
- Tracking reseed: a second session with unchanged num_balls → seeds equal the previous result. Changing num_balls to 4 → seeds {40,80,120,160,…}, y=90.
- Watchdog: TIMEOUT_CYCLES=100, no km_valid.
  - timeout_out and km_rst_out strobe 101 cycles after SOLVE entry.
  - centroids_*_out unchanged; next arm uses default seeds.
- Drops: 300 frame_start pulses during SOLVE with DROP_W=8 → dropped_frames_out=255. A simultaneous km_valid+frame_start publishes the result and counts one drop.
- Mid-SOLVE reset: rst_in for one cycle → all outputs at reset values the next cycle, km_rst_out=1. A km_valid afterwards is ignored.
- Disabled: num_balls_in=0 with frame_start pulses → no km_rst/new_frame pulses, busy_out stays 0.
